// File: rtl/io_pkg.sv
// Shared types and widths for the IO receive frame decoder and its channel register file.
package io_pkg;

  localparam int unsigned IO_CHAN_W  = 5;
  localparam int unsigned AGC_WORD_W = 15;
  localparam int unsigned BYTE_W     = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CHAN,
    HI,
    LO,
    CSUM,
    COMMIT
  } rx_state_t;

endpackage

// File: rtl/io_chan_regfile.sv
// IO channel register file: frame and core write ports (core wins on the same
// channel), one combinational read port.
module io_chan_regfile
  import io_pkg::*;
#(
  parameter int unsigned NUM_CHAN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_we,
  input  logic [IO_CHAN_W-1:0]  frame_sel,
  input  logic [AGC_WORD_W-1:0] frame_data,
  input  logic                  core_we,
  input  logic [IO_CHAN_W-1:0]  core_sel,
  input  logic [AGC_WORD_W-1:0] core_data,
  input  logic [IO_CHAN_W-1:0]  rd_sel,
  output logic [AGC_WORD_W-1:0] rd_data
);

  logic [AGC_WORD_W-1:0] mem_q [NUM_CHAN];
  logic [AGC_WORD_W-1:0] mem_d [NUM_CHAN];

  // Core write is applied last so it overrides a frame write to the same channel.
  always_comb begin
    mem_d = mem_q;
    if (frame_we) mem_d[frame_sel] = frame_data;
    if (core_we)  mem_d[core_sel]  = core_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_sel];

endmodule

// File: rtl/io_rx_frame_decoder.sv
// Parses SYNC/CHAN/HI/LO serial frames into 15-bit words written to the IO channel
// file. Define IO_RX_CHECKSUM_EN to require a trailing CHAN^HI^LO checksum byte.
module io_rx_frame_decoder
  import io_pkg::*;
#(
  parameter int unsigned      NUM_CHAN       = 32,
  parameter logic [BYTE_W-1:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int unsigned      TIMEOUT_CYCLES = 100000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [BYTE_W-1:0]     rx_data,
  input  logic                  rx_valid,
  input  logic [IO_CHAN_W-1:0]  IO_read_sel,
  output logic [AGC_WORD_W-1:0] IO_read_data,
  input  logic                  IO_write_en,
  input  logic [IO_CHAN_W-1:0]  IO_write_sel,
  input  logic [AGC_WORD_W-1:0] IO_write_data,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [7:0]            err_count
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t             state_q, state_d;
  logic [IO_CHAN_W-1:0]  chan_q, chan_d;
  logic [6:0]            hi_q, hi_d;
  logic [BYTE_W-1:0]     lo_q, lo_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            err_count_q, err_count_d;
  logic                  in_frame_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_frame_c = (state_q == CHAN) || (state_q == HI) ||
                      (state_q == LO)   || (state_q == CSUM);

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    tmo_d       = '0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      // COMMIT also behaves as IDLE for a byte arriving in the same cycle.
      IDLE, COMMIT: begin
        frame_ok_d = (state_q == COMMIT);
        state_d    = (rx_valid && (rx_data == SYNC_BYTE)) ? CHAN : IDLE;
      end
      CHAN: if (rx_valid) begin
        if (rx_data[7:5] != 3'b000) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          chan_d  = rx_data[4:0];
          state_d = HI;
        end
      end
      HI: if (rx_valid) begin
        if (rx_data[7]) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          hi_d    = rx_data[6:0];
          state_d = LO;
        end
      end
      LO: if (rx_valid) begin
        lo_d = rx_data;
`ifdef IO_RX_CHECKSUM_EN
        state_d = CSUM;
`else
        state_d = COMMIT;
`endif
      end
`ifdef IO_RX_CHECKSUM_EN
      CSUM: if (rx_valid) begin
        if (rx_data == ({3'b000, chan_q} ^ {1'b0, hi_q} ^ lo_q)) begin
          state_d = COMMIT;
        end else begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Inter-byte gap limit inside a frame; any received byte restarts the count.
    if (in_frame_c && !rx_valid) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (frame_err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  io_chan_regfile #(
    .NUM_CHAN(NUM_CHAN)
  ) u_regfile (
    .clk       (clock),
    .rst_n     (reset_n),
    .frame_we  (state_q == COMMIT),
    .frame_sel (chan_q),
    .frame_data({hi_q, lo_q}),
    .core_we   (IO_write_en),
    .core_sel  (IO_write_sel),
    .core_data (IO_write_data),
    .rd_sel    (IO_read_sel),
    .rd_data   (IO_read_data)
  );

  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule
